// File: rtl/f_prefetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// f_prefetch_queue: runs ahead of decode issuing sequential fetches, buffers returned
// words in order, and flushes/squashes everything on a branch redirect.
module f_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                        clock,
    input  logic                        reset_n,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [XLEN-1:0]             imem_req_addr,
    input  logic                        imem_rsp_valid,
    input  logic [ILEN-1:0]             imem_rsp_data,
    input  logic                        br_en,
    input  logic [XLEN-1:0]             br_addr,
    output logic                        fd_valid,
    input  logic                        fd_ready,
    output logic [XLEN-1:0]             fd_pc,
    output logic [ILEN-1:0]             fd_instr,
    output logic [$clog2(QDEPTH):0]     occupancy
);
    localparam int              AW         = $clog2(QDEPTH);
    localparam int              CW         = AW + 1;
    localparam logic [CW:0]     QDEPTH_SUM = (CW+1)'(QDEPTH);

    logic [XLEN-1:0] pc_req_reg, pc_req_next;
    logic [XLEN-1:0] pc_rsp_reg, pc_rsp_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   drop_reg, drop_next;
    logic [AW-1:0]   head_reg, head_next;
    logic [AW-1:0]   tail_reg, tail_next;

    logic [XLEN-1:0] pc_mem    [QDEPTH];
    logic [ILEN-1:0] instr_mem [QDEPTH];

    logic            req_fire;
    logic            pop;
    logic            push;
    logic [CW:0]     credit_sum;
    logic [QDEPTH-1:0] wr_en;

    // Every slot is either queued or reserved by an in-flight request, so a
    // response can never find the queue full.
    assign credit_sum     = {1'b0, count_reg} + {1'b0, outstanding_reg};
    assign imem_req_valid = reset_n && !br_en && (credit_sum < QDEPTH_SUM);
    assign imem_req_addr  = pc_req_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign fd_valid  = (count_reg != '0) && !br_en;
    assign fd_pc     = pc_mem[head_reg];
    assign fd_instr  = instr_mem[head_reg];
    assign occupancy = count_reg;
    assign pop       = fd_valid && fd_ready;

    always_comb begin
        pc_req_next      = pc_req_reg;
        pc_rsp_next      = pc_rsp_reg;
        count_next       = count_reg;
        drop_next        = drop_reg;
        head_next        = head_reg;
        tail_next        = tail_reg;
        push             = 1'b0;
        outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rsp_valid);
        if (br_en) begin
            // Whatever is still in flight after this cycle's response belongs to the old path.
            pc_req_next = br_addr;
            pc_rsp_next = br_addr;
            count_next  = '0;
            head_next   = '0;
            tail_next   = '0;
            drop_next   = outstanding_next;
        end else begin
            if (req_fire) begin
                pc_req_next = pc_req_reg + XLEN'(4);
            end
            if (imem_rsp_valid) begin
                if (drop_reg != '0) begin
                    drop_next = drop_reg - CW'(1);
                end else begin
                    push        = 1'b1;
                    tail_next   = tail_reg + AW'(1);
                    pc_rsp_next = pc_rsp_reg + XLEN'(4);
                end
            end
            if (pop) begin
                head_next = head_reg + AW'(1);
            end
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_req_reg      <= RESET_PC;
            pc_rsp_reg      <= RESET_PC;
            count_reg       <= '0;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            head_reg        <= '0;
            tail_reg        <= '0;
        end else begin
            pc_req_reg      <= pc_req_next;
            pc_rsp_reg      <= pc_rsp_next;
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
            head_reg        <= head_next;
            tail_reg        <= tail_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < QDEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (tail_reg == AW'(gi));
        end
    endgenerate

    // Queue payload carries no reset; count_reg alone decides what is valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (wr_en[i]) begin
                pc_mem[i]    <= pc_rsp_reg;
                instr_mem[i] <= imem_rsp_data;
            end
        end
    end

    a_rsp_needs_outstanding: assert property (
        @(posedge clock) disable iff (!reset_n) imem_rsp_valid |-> (outstanding_reg != '0));
    a_br_addr_aligned: assert property (
        @(posedge clock) disable iff (!reset_n) br_en |-> (br_addr[1:0] == 2'b00));

endmodule
`default_nettype wire

// File: tb/tb_f_prefetch_queue.sv
`timescale 1ns/1ps
// Randomized bench for f_prefetch_queue: in-order memory model with variable latency,
// a fetch-order reference model and a scoreboard checked by an independent pop monitor.
module tb_f_prefetch_queue;
    localparam int          XLEN     = 32;
    localparam int          ILEN     = 32;
    localparam int          QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          CW       = $clog2(QDEPTH) + 1;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            imem_req_valid, imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            br_en;
    logic [XLEN-1:0] br_addr;
    logic            fd_valid, fd_ready;
    logic [XLEN-1:0] fd_pc;
    logic [ILEN-1:0] fd_instr;
    logic [CW-1:0]   occupancy;

    f_prefetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .br_en(br_en), .br_addr(br_addr),
        .fd_valid(fd_valid), .fd_ready(fd_ready), .fd_pc(fd_pc),
        .fd_instr(fd_instr), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; int epoch; longint due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } sb_t;

    mreq_t       memq[$];
    sb_t         sb[$];
    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    longint      cyc      = 0;
    int          epoch    = 0;
    int          m_occ    = 0;
    logic [31:0] exp_pc   = RESET_PC;

    int          lat_min = 1, lat_max = 1, ready_pct = 100, fdr_pct = 100, br_pct = 0;
    logic        br_force = 1'b0;
    logic [31:0] br_force_addr = 32'h0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Stimulus driver: memory responder plus random handshakes and redirects.
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (!reset_n) begin
                imem_rsp_valid = 1'b0;
                br_en          = 1'b0;
            end else begin
                imem_req_ready = ($urandom_range(99) < ready_pct);
                fd_ready       = ($urandom_range(99) < fdr_pct);
                if (br_force) begin
                    br_en    = 1'b1;
                    br_addr  = br_force_addr;
                    br_force = 1'b0;
                end else if ($urandom_range(999) < br_pct) begin
                    br_en   = 1'b1;
                    br_addr = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                       : ($urandom & 32'hFFFF_FFFC);
                end else begin
                    br_en = 1'b0;
                end
                if (memq.size() > 0 && memq[0].due <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_fn(memq[0].addr);
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    // Reference model: next-fetch PC, credits and queue occupancy from the rules.
    always @(negedge clock) begin
        if (!reset_n) begin
            memq.delete();
            sb.delete();
            m_occ  = 0;
            exp_pc = RESET_PC;
            epoch++;
        end else begin
            logic br;
            logic pop_exp;
            mreq_t e;
            br      = br_en;
            pop_exp = (m_occ != 0) && !br && fd_ready;
            check("req_valid", imem_req_valid, (!br && (m_occ + memq.size() < QDEPTH)));
            check("fd_valid", fd_valid, ((m_occ != 0) && !br));
            check("occupancy", occupancy, m_occ);
            if (imem_rsp_valid) begin
                if (memq.size() == 0) begin
                    $display("FAIL rsp_without_request: got response, expected none");
                end else begin
                    e = memq.pop_front();
                    if (!br && e.epoch == epoch) m_occ++;
                end
            end
            if (pop_exp) m_occ--;
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_pc);
                memq.push_back('{addr: imem_req_addr, epoch: epoch,
                                 due: cyc + $urandom_range(lat_max, lat_min)});
                sb.push_back('{pc: exp_pc, instr: mem_fn(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
            if (br) begin
                epoch++;
                sb.delete();
                exp_pc = br_addr;
                m_occ  = 0;
            end
        end
    end

    // Monitor: every word handed to decode must be the oldest surviving fetch.
    always @(negedge clock) begin
        if (reset_n && fd_valid && fd_ready) begin
            if (sb.size() == 0) begin
                chk_cnt++;
                $display("FAIL pop_empty: got pc=%08h, expected no pop", fd_pc);
            end else begin
                sb_t x;
                x = sb.pop_front();
                $display("pop pc=%08h instr=%08h", fd_pc, fd_instr);
                check("fd_pc", fd_pc, x.pc);
                check("fd_instr", fd_instr, x.instr);
            end
        end
    end

    initial begin
        reset_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; br_en = 1'b0; br_addr = '0; fd_ready = 1'b0;
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b1;

        // Streaming, 1-cycle memory, decode always ready
        repeat (30) @(posedge clock);

        // Decode stalled: queue fills, credits stop requests
        fdr_pct = 0;
        repeat (12) @(posedge clock);
        @(negedge clock); #1;
        check("full_occupancy", occupancy, QDEPTH);
        check("full_no_req", imem_req_valid, 0);
        fdr_pct = 100;
        @(posedge clock); #2 fdr_pct = 0;
        repeat (4) @(posedge clock);
        @(negedge clock); #1;
        check("refill_occupancy", occupancy, QDEPTH);

        // Latency 3 with redirect to 0x100
        fdr_pct = 100; lat_min = 3; lat_max = 3;
        repeat (20) @(posedge clock);
        @(negedge clock); br_force_addr = 32'h100; br_force = 1'b1;
        repeat (20) @(posedge clock);

        // Address wrap
        lat_min = 1; lat_max = 2;
        @(negedge clock); br_force_addr = 32'hFFFF_FFF8; br_force = 1'b1;
        repeat (20) @(posedge clock);

        // Randomized traffic
        lat_min = 1; lat_max = 4; ready_pct = 70; fdr_pct = 60; br_pct = 30;
        repeat (1500) @(posedge clock);

        // Reset mid-burst with full queue
        br_pct = 0; ready_pct = 100; fdr_pct = 0; lat_min = 1; lat_max = 1;
        repeat (15) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        check("rst_fd_valid", fd_valid, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_occupancy", occupancy, 0);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        fdr_pct = 100;
        repeat (20) @(posedge clock);

        @(negedge clock);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
